// File: rtl/mkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mkt_pkg
//  Purpose  : Shared types and default widths for the market-data trigger
//             path (trigger FSM states, order side, order record).
//  Revision : 1.0 - initial release
// ============================================================================
package mkt_pkg;

    // Default price width in integer ticks, matching the parser's price_data
    localparam int c_PRICE_W = 32;
    // Default order sequence number width
    localparam int c_SEQ_W   = 16;

    // Trigger FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        HOLD     = 2'd2,
        COOLDOWN = 2'd3
    } trig_state_t;

    // Order side as carried on m_order_side
    typedef enum logic {
        BUY  = 1'b0,
        SELL = 1'b1
    } side_t;

    // Order record at the default widths
    typedef struct packed {
        side_t                side;
        logic [c_PRICE_W-1:0] price;
        logic [c_SEQ_W-1:0]   seq;
    } order_t;

endpackage : mkt_pkg
`default_nettype wire

// File: rtl/trig_cooldown.sv
`default_nettype none
// ============================================================================
//  Module   : trig_cooldown
//  Purpose  : Loadable down-counter for the post-order quiet period. A load
//             sets the count to COOLDOWN_CYCLES-1; done is high at zero.
//             With COOLDOWN_CYCLES = 0 there is no counter and done is
//             permanently high.
//  Revision : 1.0 - initial release
// ============================================================================
module trig_cooldown #(
    parameter int COOLDOWN_CYCLES = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    generate
        if (COOLDOWN_CYCLES == 0) begin : g_no_cooldown
            // No quiet period: the counter and its controls are not needed
            logic w_unused;
            assign w_unused = ^{clk, rst, load};
            assign done     = 1'b1;
        end else begin : g_cooldown
            localparam int c_CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
            localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(COOLDOWN_CYCLES - 1);
            localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

            logic [c_CNT_W-1:0] r_count;

            // Load on order acceptance, then count down to zero and stay there
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (load) begin
                    r_count <= c_LOAD;
                end else if (r_count != '0) begin
                    r_count <= r_count - c_ONE;
                end
            end

            assign done = (r_count == '0);
        end
    endgenerate

endmodule : trig_cooldown
`default_nettype wire

// File: rtl/price_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : price_trigger
//  Purpose  : Compares each parser price update against buy/sell thresholds
//             and issues at most one order per crossing on a valid/ready
//             handshake, with hysteresis re-arm and a post-order cooldown.
//             Optional statistics counters under PRICE_TRIGGER_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module price_trigger
    import mkt_pkg::*;
#(
    parameter int PRICE_W         = c_PRICE_W,
    parameter int SEQ_W           = c_SEQ_W,
    parameter int HYST_TICKS      = 10,
    parameter int COOLDOWN_CYCLES = 125
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PRICE_W-1:0] buy_threshold,
    input  logic [PRICE_W-1:0] sell_threshold,
    input  logic [PRICE_W-1:0] price_data,
    input  logic               price_valid,
    output logic               m_order_valid,
    input  logic               m_order_ready,
    output logic               m_order_side,
    output logic [PRICE_W-1:0] m_order_price,
    output logic [SEQ_W-1:0]   m_order_seq,
    output logic               busy
`ifdef PRICE_TRIGGER_STATS_EN
    ,
    output logic [31:0]        order_count,
    output logic [31:0]        drop_count
`endif
);

    localparam logic [PRICE_W:0] c_HYST        = (PRICE_W + 1)'(HYST_TICKS);
    localparam logic [SEQ_W-1:0] c_SEQ_ONE     = SEQ_W'(1);
    localparam bit               c_NO_COOLDOWN = (COOLDOWN_CYCLES == 0);

    trig_state_t        r_state;
    logic               r_buy_armed;
    logic               r_sell_armed;
    logic               r_valid;
    side_t              r_side;
    logic [PRICE_W-1:0] r_price;
    logic [SEQ_W-1:0]   r_seq;
    logic               r_busy;

    logic               w_buy_hit;
    logic               w_sell_hit;
    logic               w_buy_rearm;
    logic               w_sell_rearm;
    logic               w_eval;
    logic               w_fire_buy;
    logic               w_fire_sell;
    logic               w_accept;
    logic               w_cd_done;

    // Widened by one bit so threshold +/- hysteresis never wraps
    assign w_buy_rearm  = {1'b0, price_data} > ({1'b0, buy_threshold} + c_HYST);
    assign w_sell_rearm = ({1'b0, price_data} + c_HYST) < {1'b0, sell_threshold};

    assign w_buy_hit    = r_buy_armed  && (price_data <= buy_threshold);
    assign w_sell_hit   = r_sell_armed && (price_data >= sell_threshold);

    // Prices are only evaluated for triggering while ARMED and still enabled
    assign w_eval       = price_valid && enable && (r_state == ARMED);
    assign w_fire_buy   = w_eval && w_buy_hit;
    assign w_fire_sell  = w_eval && w_sell_hit && !w_buy_hit;
    assign w_accept     = r_valid && m_order_ready;

    trig_cooldown #(
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES)
    ) u_cooldown (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .done (w_cd_done)
    );

    // Arm flags: any hit disarms its side (even when BUY wins over SELL),
    // and every price update in any state may re-arm past the hysteresis band
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buy_armed  <= 1'b1;
            r_sell_armed <= 1'b1;
        end else if (price_valid) begin
            if (w_eval && w_buy_hit) begin
                r_buy_armed <= 1'b0;
            end else if (w_buy_rearm) begin
                r_buy_armed <= 1'b1;
            end
            if (w_eval && w_sell_hit) begin
                r_sell_armed <= 1'b0;
            end else if (w_sell_rearm) begin
                r_sell_armed <= 1'b1;
            end
        end
    end

    // Trigger FSM with registered order outputs, sequence number and busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_side  <= BUY;
            r_price <= '0;
            r_seq   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_fire_buy || w_fire_sell) begin
                        r_state <= HOLD;
                        r_valid <= 1'b1;
                        r_side  <= w_fire_buy ? BUY : SELL;
                        r_price <= price_data;
                        r_busy  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Enable is ignored here: a pending order is always delivered
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_seq   <= r_seq + c_SEQ_ONE;
                        if (c_NO_COOLDOWN) begin
                            r_state <= enable ? ARMED : IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    if (w_cd_done) begin
                        r_state <= enable ? ARMED : IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_order_valid = r_valid;
    assign m_order_side  = r_side;
    assign m_order_price = r_price;
    assign m_order_seq   = r_seq;
    assign busy          = r_busy;

`ifdef PRICE_TRIGGER_STATS_EN
    logic        w_drop;
    logic [31:0] r_order_count;
    logic [31:0] r_drop_count;

    assign w_drop = price_valid &&
                    ((r_state == IDLE) || (r_state == HOLD) || (r_state == COOLDOWN));

    // Saturating counts of accepted orders and of updates that could not trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_order_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_accept && (r_order_count != '1)) begin
                r_order_count <= r_order_count + 32'd1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign order_count = r_order_count;
    assign drop_count  = r_drop_count;
`endif

endmodule : price_trigger
`default_nettype wire

// File: tb/tb_price_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_price_trigger
//  Purpose  : Self-checking bench for price_trigger. A transaction-level
//             reference model predicts orders, busy and statistics; a monitor
//             compares the DUT against the predicted order queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_price_trigger;

    localparam int PW   = 32;
    localparam int SW   = 4;
    localparam int HYST = 10;
    localparam int CD   = 125;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [PW-1:0] buy_threshold;
    logic [PW-1:0] sell_threshold;
    logic [PW-1:0] price_data;
    logic          price_valid;
    logic          m_order_valid;
    logic          m_order_ready;
    logic          m_order_side;
    logic [PW-1:0] m_order_price;
    logic [SW-1:0] m_order_seq;
    logic          busy;
`ifdef PRICE_TRIGGER_STATS_EN
    logic [31:0]   order_count;
    logic [31:0]   drop_count;
`endif

    price_trigger #(
        .PRICE_W         (PW),
        .SEQ_W           (SW),
        .HYST_TICKS      (HYST),
        .COOLDOWN_CYCLES (CD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .buy_threshold  (buy_threshold),
        .sell_threshold (sell_threshold),
        .price_data     (price_data),
        .price_valid    (price_valid),
        .m_order_valid  (m_order_valid),
        .m_order_ready  (m_order_ready),
        .m_order_side   (m_order_side),
        .m_order_price  (m_order_price),
        .m_order_seq    (m_order_seq),
        .busy           (busy)
`ifdef PRICE_TRIGGER_STATS_EN
        ,
        .order_count    (order_count),
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            side;
        logic [PW-1:0] price;
        logic [SW-1:0] seq;
        int            fire;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    // Reference model state (transaction level)
    bit            m_buy_arm, m_sell_arm, m_pending, m_prev_en;
    int            m_fire, m_ready_at, m_orders, m_drops;
    logic [SW-1:0] m_seq;

    // Expectations for the cycle currently being driven
    bit exp_busy;
    int exp_orders, exp_drops;

    int errors = 0;
    int checks = 0;
    bit mon_on = 1'b0;

    task automatic model_reset();
        m_buy_arm  = 1'b1;
        m_sell_arm = 1'b1;
        m_pending  = 1'b0;
        m_prev_en  = 1'b0;
        m_fire     = 0;
        m_ready_at = 0;
        m_orders   = 0;
        m_drops    = 0;
        m_seq      = '0;
        exp_busy   = 1'b0;
        exp_orders = 0;
        exp_drops  = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs and advance the reference model.
    // Rules: an order is live one cycle after it fires and is taken on the
    // first cycle ready is high; the next price may trigger COOLDOWN+1 cycles
    // after acceptance; triggering also needs enable high this and last cycle.
    task automatic step(input bit pv, input logic [PW-1:0] p, input bit rdy, input bit en);
        int      t;
        bit      pend_before, live, bh, sh;
        longint  lp, lb, ls;
        @(posedge clk);
        #1;
        price_valid   = pv;
        price_data    = p;
        m_order_ready = rdy;
        enable        = en;
        mon_on        = 1'b1;
        t             = cyc;

        exp_busy   = m_pending || (t < m_ready_at);
        exp_orders = m_orders;
        exp_drops  = m_drops;

        pend_before = m_pending;
        live = !pend_before && (t >= m_ready_at) && m_prev_en && en;
        if (pv && !live && (pend_before || (t < m_ready_at) || !m_prev_en))
            m_drops++;

        if (m_pending && rdy) begin
            m_pending  = 1'b0;
            m_seq      = m_seq + 1'b1;
            m_ready_at = t + 1 + CD;
            m_orders++;
        end

        if (pv) begin
            lp = longint'(p);
            lb = longint'(buy_threshold);
            ls = longint'(sell_threshold);
            bh = live && m_buy_arm  && (lp <= lb);
            sh = live && m_sell_arm && (lp >= ls);
            if (bh || sh) begin
                exp_q.push_back('{side: !bh, price: p, seq: m_seq, fire: t});
                m_pending = 1'b1;
                m_fire    = t;
            end
            if (bh) m_buy_arm = 1'b0;
            else if (lp > lb + HYST) m_buy_arm = 1'b1;
            if (sh) m_sell_arm = 1'b0;
            else if (lp + HYST < ls) m_sell_arm = 1'b1;
        end
        m_prev_en = en;
    endtask

    task automatic idle(input int n, input bit rdy, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, en);
    endtask

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: compares DUT against the model's predicted order stream
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, exp_busy);
            end
`ifdef PRICE_TRIGGER_STATS_EN
            checks++;
            if (order_count !== exp_orders || drop_count !== exp_drops) begin
                errors++;
                $display("FAIL stats cyc=%0d got orders=%0d drops=%0d expected orders=%0d drops=%0d",
                         cyc, order_count, drop_count, exp_orders, exp_drops);
            end
`endif
            if (exp_q.size() > 0 && cyc > exp_q[0].fire) begin
                checks++;
                if (m_order_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL order_valid cyc=%0d got %b expected 1", cyc, m_order_valid);
                end else if (m_order_side !== exp_q[0].side || m_order_price !== exp_q[0].price ||
                             m_order_seq !== exp_q[0].seq) begin
                    errors++;
                    $display("FAIL order_fields cyc=%0d got side=%b price=%0d seq=%0d expected side=%b price=%0d seq=%0d",
                             cyc, m_order_side, m_order_price, m_order_seq,
                             exp_q[0].side, exp_q[0].price, exp_q[0].seq);
                end
                if (m_order_ready) begin
                    if (m_order_valid === 1'b1) acc_q.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end else begin
                checks++;
                if (m_order_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d got %b expected 0", cyc, m_order_valid);
                end
            end
        end
    end

    initial begin : stim
        int d0;
        int d1;
        bit en_r;
        rst            = 1'b1;
        enable         = 1'b0;
        price_valid    = 1'b0;
        price_data     = '0;
        m_order_ready  = 1'b0;
        buy_threshold  = 32'd1000;
        sell_threshold = 32'd2000;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", m_order_valid, 0);
        chk("rst_side",  m_order_side,  0);
        chk("rst_price", m_order_price, 0);
        chk("rst_seq",   m_order_seq,   0);
        chk("rst_busy",  busy,          0);
`ifdef PRICE_TRIGGER_STATS_EN
        chk("rst_order_count", order_count, 0);
        chk("rst_drop_count",  drop_count,  0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Buy crossing and hysteresis re-arm
        idle(2, 1'b0, 1'b1);
        step(1'b1, 32'd900, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle(CD + 5, 1'b1, 1'b1);
        step(1'b1, 32'd900, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);
        step(1'b1, 32'd1011, 1'b1, 1'b1);
        step(1'b1, 32'd900, 1'b1, 1'b1);
        idle(CD + 5, 1'b1, 1'b1);

        // Enable dropped during HOLD: order still delivered, then IDLE
        step(1'b1, 32'd2500, 1'b0, 1'b1);
        idle(3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(CD + 5, 1'b0, 1'b0);
        step(1'b1, 32'd900, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);
        step(1'b1, 32'd900, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);

        // Reset in the middle of HOLD
        mon_on = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_before_rst", m_order_valid, 1);
        rst         = 1'b1;
        enable      = 1'b0;
        price_valid = 1'b0;
        #1;
        chk("midhold_rst_valid", m_order_valid, 0);
        chk("midhold_rst_seq",   m_order_seq,   0);
        chk("midhold_rst_busy",  busy,          0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both thresholds hit: BUY wins and SELL is disarmed until re-armed
        buy_threshold  = 32'd2000;
        sell_threshold = 32'd1000;
        idle(2, 1'b0, 1'b1);
        step(1'b1, 32'd1500, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle(CD + 5, 1'b1, 1'b1);
        step(1'b1, 32'd1500, 1'b0, 1'b1);
        step(1'b1, 32'd989, 1'b0, 1'b1);
        step(1'b1, 32'd1500, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        idle(CD + 5, 1'b1, 1'b1);

        // Backpressure: 20 cycles not ready, updates every 4 cycles
        buy_threshold  = 32'd1000;
        sell_threshold = 32'd2000;
        step(1'b1, 32'd1500, 1'b0, 1'b1);
        step(1'b1, 32'd900, 1'b0, 1'b1);
`ifdef PRICE_TRIGGER_STATS_EN
        d0 = drop_count;
`else
        d0 = 0;
`endif
        for (int i = 0; i < 20; i++)
            step((i % 4) == 0, (i % 8 == 0) ? 32'd2500 : 32'd900, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
`ifdef PRICE_TRIGGER_STATS_EN
        d1 = drop_count;
        chk("backpressure_drops", d1 - d0, 5);
`else
        d1 = d0;
`endif
        idle(CD + 5, 1'b1, 1'b1);

        // Cooldown spacing with a trigger price every cycle; seq wraps
        acc_q.delete();
        for (int i = 0; i < 20 * (CD + 2) + 10; i++)
            step(1'b1, (i % 2) ? 32'd2500 : 32'd900, 1'b1, 1'b1);
        checks++;
        if (acc_q.size() < (1 << SW) + 1) begin
            errors++;
            $display("FAIL cooldown_orders: got %0d expected at least %0d", acc_q.size(), (1 << SW) + 1);
        end
        for (int i = 1; i < acc_q.size(); i++)
            chk("order_spacing", acc_q[i] - acc_q[i-1], CD + 2);
        idle(CD + 5, 1'b1, 1'b1);

        // Randomized traffic against the reference model
        en_r = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (i % 2500 == 0) begin
                buy_threshold  = 32'd900  + $urandom_range(0, 200);
                sell_threshold = 32'd1800 + $urandom_range(0, 400);
                if ($urandom_range(0, 3) == 0) begin
                    d0             = buy_threshold;
                    buy_threshold  = sell_threshold;
                    sell_threshold = d0;
                end
            end
            if ($urandom_range(0, 299) == 0) en_r = !en_r;
            step($urandom_range(0, 1) == 1, PW'($urandom_range(800, 2300)),
                 $urandom_range(0, 9) < 6, en_r);
        end

        // Drain
        idle(CD + 10, 1'b1, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_price_trigger
`default_nettype wire

// File: doc/price_trigger.md
# price_trigger

Order-trigger stage directly downstream of `udp_parser` in the 125 MHz `gmii_rx_clk` domain. It consumes the parser's single-cycle `price_data`/`price_valid` updates for the target symbol and compares each price against buy and sell thresholds. It emits at most one order request per crossing on a valid/ready handshake. Hysteresis re-arm and a post-order cooldown limit the order rate.

## Interface
- `PRICE_W`, 32: price width in integer ticks, unsigned; matches `price_data`.
- `SEQ_W`, 16: order sequence number width.
- `HYST_TICKS`, 10: re-arm hysteresis in ticks.
- `COOLDOWN_CYCLES`, 125: clocks of mandatory quiet after each accepted order (1 µs at 125 MHz); 0 allowed.

- `clk`  in  1  sole clock; `gmii_rx_clk` in the top level.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  trigger enable, level.
- `buy_threshold`  in  PRICE_W  BUY when price <= this value; quasi-static.
- `sell_threshold`  in  PRICE_W  SELL when price >= this value; quasi-static.
- `price_data`  in  PRICE_W  price from the parser.
- `price_valid`  in  1  one-cycle update strobe; no backpressure.
- `m_order_valid`  out  1  order pending.
- `m_order_ready`  in  1  consumer accepts the order.
- `m_order_side`  out  1  0 = BUY, 1 = SELL.
- `m_order_price`  out  PRICE_W  price that triggered the order.
- `m_order_seq`  out  SEQ_W  order sequence number.
- `busy`  out  1  high in HOLD or COOLDOWN.

## Operation
- States: IDLE, ARMED, HOLD, COOLDOWN.
  - IDLE: leaves to ARMED when `enable`=1.
  - ARMED: returns to IDLE when `enable`=0.
  - ARMED, on `price_valid`: evaluate the price; if a trigger fires, load the output registers and go to HOLD.
  - HOLD: on `m_order_valid && m_order_ready`, increment seq and go to COOLDOWN. If `COOLDOWN_CYCLES`==0, go instead to ARMED, or to IDLE when `enable`=0.
  - COOLDOWN: counter loads `COOLDOWN_CYCLES-1` on entry and decrements each clock. At 0, go to ARMED if `enable`=1, otherwise IDLE.
- Trigger evaluation in ARMED only:
  - buy_hit = `buy_armed` && price <= `buy_threshold`.
  - sell_hit = `sell_armed` && price >= `sell_threshold`.
  - If both hit, BUY wins; SELL is not latched.
  - A firing trigger clears its own arm flag.
- Re-arm is evaluated on every `price_valid` in every state, including HOLD and COOLDOWN, using PRICE_W+1-bit arithmetic so nothing wraps:
  - `buy_armed` sets when price > `buy_threshold` + HYST_TICKS.
  - `sell_armed` sets when price + HYST_TICKS < `sell_threshold`.
- Dropped updates: a `price_valid` arriving in IDLE, HOLD or COOLDOWN never produces an order and is not queued.
- Handshake rules:
  - `m_order_valid` is never retracted before acceptance.
  - Side, price and seq stay stable while `m_order_valid`=1.
  - Dropping `enable` during HOLD does not cancel the pending order.
- `m_order_seq` starts at 0, increments per accepted order, and wraps from all-ones to 0.
- Reset values:
  - State IDLE; both arm flags 1.
  - `m_order_valid`, `m_order_side`, `m_order_price`, `m_order_seq`, `busy` all 0.
  - Cooldown counter 0.
- Reset asserted mid-HOLD drops the pending order without a handshake.

## Timing
- Latency: `price_valid` at cycle N (ARMED, hit) gives `m_order_valid`=1 at N+1. All outputs are registered.
- With `m_order_ready` held high, `m_order_valid` stays high exactly one cycle.
- Earliest next order after acceptance at cycle A: `price_valid` at A+1+`COOLDOWN_CYCLES`, so `m_order_valid` at A+2+`COOLDOWN_CYCLES`.
- `price_valid` in the same cycle as the HOLD handshake is dropped; its re-arm evaluation still applies.
- Thresholds are sampled in the `price_valid` cycle.

## Configuration
- `PRICE_TRIGGER_STATS_EN` defined: adds 32-bit saturating outputs `order_count` (accepted orders) and `drop_count` (`price_valid` strobes dropped in IDLE, HOLD or COOLDOWN). Both reset to 0.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

## Structure
- Package `mkt_pkg` holds:
  - `trig_state_t` (IDLE/ARMED/HOLD/COOLDOWN);
  - `side_t` (BUY=0, SELL=1);
  - `order_t` struct {side, price, seq};
  - default `PRICE_W`.
- One sub-module, `trig_cooldown`: loadable down-counter with a `done` flag, parameterised by `COOLDOWN_CYCLES`; returns done immediately when the parameter is 0.

## Test plan
- Buy crossing: thresholds 1000/2000, `enable`=1, price 900 -> next cycle valid, side 0, price 900, seq 0; accept; a second 900 gives no order until a 1011 update re-arms buy.
- Both hit: thresholds 2000/1000, price 1500 -> BUY; a following price 1500 (post-cooldown) gives no SELL until 989 re-arms sell.
- Backpressure: hold `m_order_ready`=0 for 20 cycles with price updates every 4 cycles -> outputs stable, one order only; with stats, `drop_count`=5.
- Cooldown: `COOLDOWN_CYCLES`=125, trigger prices every cycle -> accepted orders exactly 127 cycles apart; seq wraps 0xFFFF -> 0x0000.
- Enable drop and reset: deassert `enable` in HOLD -> order still delivered, then IDLE. Assert `rst` mid-HOLD -> `m_order_valid`=0 immediately, seq 0, both arms 1.
